simt_dma: RTL and testbench

//  Word-granular DMA engine between external DRAM and the banked scratch SRAM (sram_fp).

---
 rtl/simt_pkg.sv | 26 ++
 rtl/simt_dma.sv | 140 ++++++++++++++
 tb/tb_simt_dma.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/simt_pkg.sv
// Shared types for the SIMT group DMA engine: command encoding and FSM states.
package simt_pkg;

    localparam int unsigned ADDR_W    = 32;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned SRAM_AW   = 14;
    localparam int unsigned WORD_AW   = ADDR_W - 2;

    typedef enum logic [1:0] {
        DMA_NONE = 2'b00,
        DMA_D2S  = 2'b01,
        DMA_S2D  = 2'b10,
        DMA_RSVD = 2'b11
    } dma_cmd_t;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        D2S_REQ  = 3'd1,
        D2S_WR   = 3'd2,
        S2D_RD   = 3'd3,
        S2D_WAIT = 3'd4,
        S2D_REQ  = 3'd5,
        DONE     = 3'd6
    } dma_state_t;

endpackage

// File: rtl/simt_dma.sv
// Word-granular DMA between external DRAM and the banked scratch SRAM.
// One word in flight at a time; busy holds the SIMT group until the copy finishes.
module simt_dma
    import simt_pkg::*;
#(
    parameter int unsigned WIDTH_BITS = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            dmaCmd,
    input  logic [ADDR_W-1:0]     dmaSrcAddress,
    input  logic [ADDR_W-1:0]     dmaDstAddress,
    input  logic [WIDTH_BITS-1:0] dmaWidth,
    output logic                  busy,
    output logic                  done,
    output logic [SRAM_AW-1:0]    sramAddr,
    output logic                  sramWe,
    output logic [DATA_W-1:0]     sramWd,
    input  logic [DATA_W-1:0]     sramRd,
    output logic                  dramReq,
    output logic                  dramWe,
    output logic [ADDR_W-1:0]     dramAddr,
    output logic [DATA_W-1:0]     dramWd,
    input  logic [DATA_W-1:0]     dramRd,
    input  logic                  dramAck
);

    dma_state_t            state;
    dma_state_t            state_nx;
    logic [WORD_AW-1:0]    src_w;
    logic [WORD_AW-1:0]    dst_w;
    logic [WIDTH_BITS-1:0] remaining;
    logic [DATA_W-1:0]     data_q;
    logic                  last_word;
    logic                  cmd_start;
    logic                  unused_addr_lsbs;

    // Addresses are word aligned; byte offsets are dropped at capture.
    assign unused_addr_lsbs = ^{dmaSrcAddress[1:0], dmaDstAddress[1:0]};
    assign cmd_start        = (dmaCmd == DMA_D2S) || (dmaCmd == DMA_S2D);
    // Tested before the decrement, so the counter never wraps below zero.
    assign last_word        = (remaining == WIDTH_BITS'(1));

    // State, address walkers, word counter and the single data holding register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            src_w     <= '0;
            dst_w     <= '0;
            remaining <= '0;
            data_q    <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (cmd_start) begin
                        src_w     <= dmaSrcAddress[ADDR_W-1:2];
                        dst_w     <= dmaDstAddress[ADDR_W-1:2];
                        remaining <= dmaWidth;
                    end
                end
                D2S_REQ: begin
                    if (dramAck) data_q <= dramRd;
                end
                D2S_WR: begin
                    src_w     <= src_w + WORD_AW'(1);
                    dst_w     <= dst_w + WORD_AW'(1);
                    remaining <= remaining - WIDTH_BITS'(1);
                end
                S2D_WAIT: begin
                    data_q <= sramRd;
                end
                S2D_REQ: begin
                    if (dramAck) begin
                        src_w     <= src_w + WORD_AW'(1);
                        dst_w     <= dst_w + WORD_AW'(1);
                        remaining <= remaining - WIDTH_BITS'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Next state and memory-port decode; every non-IDLE state reports busy.
    always_comb begin
        state_nx = state;
        busy     = 1'b1;
        done     = 1'b0;
        sramAddr = '0;
        sramWe   = 1'b0;
        sramWd   = '0;
        dramReq  = 1'b0;
        dramWe   = 1'b0;
        dramAddr = '0;
        dramWd   = '0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                case (dma_cmd_t'(dmaCmd))
                    DMA_D2S: state_nx = (dmaWidth == WIDTH_BITS'(0)) ? DONE : D2S_REQ;
                    DMA_S2D: state_nx = (dmaWidth == WIDTH_BITS'(0)) ? DONE : S2D_RD;
                    default: state_nx = IDLE;
                endcase
            end
            D2S_REQ: begin
                dramReq  = 1'b1;
                dramAddr = {src_w, 2'b00};
                if (dramAck) state_nx = D2S_WR;
            end
            D2S_WR: begin
                sramWe   = 1'b1;
                sramAddr = dst_w[SRAM_AW-1:0];
                sramWd   = data_q;
                state_nx = last_word ? DONE : D2S_REQ;
            end
            S2D_RD: begin
                sramAddr = src_w[SRAM_AW-1:0];
                state_nx = S2D_WAIT;
            end
            S2D_WAIT: begin
                sramAddr = src_w[SRAM_AW-1:0];
                state_nx = S2D_REQ;
            end
            S2D_REQ: begin
                dramReq  = 1'b1;
                dramWe   = 1'b1;
                dramAddr = {dst_w, 2'b00};
                dramWd   = data_q;
                if (dramAck) state_nx = last_word ? DONE : S2D_RD;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_simt_dma.sv
// Bench for simt_dma: SRAM model with one-cycle read latency, DRAM model with programmable ack delay.
module tb_simt_dma;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  dmaCmd;
    logic [31:0] dmaSrcAddress;
    logic [31:0] dmaDstAddress;
    logic [9:0]  dmaWidth;
    logic        busy;
    logic        done;
    logic [13:0] sramAddr;
    logic        sramWe;
    logic [31:0] sramWd;
    logic [31:0] sramRd;
    logic        dramReq;
    logic        dramWe;
    logic [31:0] dramAddr;
    logic [31:0] dramWd;
    logic [31:0] dramRd;
    logic        dramAck;

    always #5 clk = ~clk;

    simt_dma dut (
        .clk(clk), .reset(reset), .dmaCmd(dmaCmd),
        .dmaSrcAddress(dmaSrcAddress), .dmaDstAddress(dmaDstAddress), .dmaWidth(dmaWidth),
        .busy(busy), .done(done),
        .sramAddr(sramAddr), .sramWe(sramWe), .sramWd(sramWd), .sramRd(sramRd),
        .dramReq(dramReq), .dramWe(dramWe), .dramAddr(dramAddr), .dramWd(dramWd),
        .dramRd(dramRd), .dramAck(dramAck)
    );

    logic [31:0] sram [0:16383];
    logic [31:0] dram [logic [31:0]];
    logic [13:0] sram_addr_q = '0;
    int          dcnt = 0;
    int          ack_delay = 0;
    bit          stray_ack = 1'b0;
    int          n_swr = 0, n_hs = 0, n_dwr = 0, n_done = 0, n_busy = 0;
    bit          prev_done = 1'b0, prev_req = 1'b0, prev_ack = 1'b0;
    logic [31:0] prev_addr = '0;
    int          n_checks = 0, n_fail = 0;

    function automatic logic [31:0] dkey(input logic [31:0] a);
        return {2'b00, a[31:2]};
    endfunction

    function automatic logic [31:0] dram_rd(input logic [31:0] a);
        if (dram.exists(dkey(a))) return dram[dkey(a)];
        return a ^ 32'h5A5A_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    // One clock: models and monitors act on the falling edge, away from the DUT's sampling edge.
    task automatic cyc();
        @(negedge clk);
        if (dramReq && prev_req && !prev_ack) check("dram_addr_stable", dramAddr, prev_addr);
        sramRd = sram[sram_addr_q];
        if (sramWe) begin
            sram[sramAddr] = sramWd;
            n_swr++;
        end
        sram_addr_q = sramAddr;
        if (reset) begin
            dramAck = 1'b0;
            dcnt    = 0;
        end else if (dramAck) begin
            dramAck = 1'b0;
        end else if (stray_ack) begin
            dramAck   = 1'b1;
            stray_ack = 1'b0;
        end else if (dramReq) begin
            if (dcnt >= ack_delay) begin
                dramAck = 1'b1;
                dcnt    = 0;
                n_hs++;
                if (dramWe) begin
                    dram[dkey(dramAddr)] = dramWd;
                    n_dwr++;
                end else begin
                    dramRd = dram_rd(dramAddr);
                end
            end else begin
                dcnt++;
            end
        end
        if (done) n_done++;
        if (busy) n_busy++;
        if (prev_done) check("busy_after_done", 32'(busy), 32'd0);
        prev_done = done;
        prev_req  = dramReq;
        prev_ack  = dramAck;
        prev_addr = dramAddr;
    endtask

    task automatic run_xfer(input logic [1:0] cmd, input logic [31:0] src, input logic [31:0] dst,
                            input logic [9:0] w, input int delay, input bit run,
                            output int swr, output int hs, output int dwr, output int bsy, output int dn);
        int b_swr, b_hs, b_dwr, b_bsy, b_dn, k;
        b_swr = n_swr; b_hs = n_hs; b_dwr = n_dwr; b_bsy = n_busy; b_dn = n_done;
        ack_delay     = delay;
        dmaCmd        = cmd;
        dmaSrcAddress = src;
        dmaDstAddress = dst;
        dmaWidth      = w;
        cyc();
        dmaCmd = 2'b00;
        k = 0;
        if (run) begin
            while (n_done == b_dn && k < 5000) begin
                cyc();
                k++;
            end
            cyc();
        end else begin
            repeat (5) cyc();
        end
        swr = n_swr - b_swr; hs = n_hs - b_hs; dwr = n_dwr - b_dwr;
        bsy = n_busy - b_bsy; dn = n_done - b_dn;
    endtask

    typedef struct {
        logic [1:0]  cmd;
        logic [31:0] src;
        logic [31:0] dst;
        logic [9:0]  w;
        int          delay;
        bit          run;
        int          swr;
        int          hs;
        int          dwr;
        int          bsy;
        int          dn;
    } vec_t;

    localparam int NV = 6;
    vec_t vt [NV];

    initial begin
        int          swr, hs, dwr, bsy, dn, k, b_swr, b_dwr, b_hs, b_dn, b_bsy, d, exp_bsy;
        logic [1:0]  cmd;
        logic [31:0] src, dst;
        logic [9:0]  w;
        logic [13:0] sidx;
        logic [31:0] expv [$];

        // cmd, src, dst, width, ack delay, runs, sram writes, handshakes, dram writes, busy cycles, done pulses
        vt[0] = '{2'b01, 32'h0000_2000, 32'h0003_FFFC, 10'd2, 0, 1'b1, 2, 2, 0, 5, 1};
        vt[1] = '{2'b01, 32'h0000_0100, 32'h0000_0000, 10'd4, 2, 1'b1, 4, 4, 0, 17, 1};
        vt[2] = '{2'b10, 32'h0000_0010, 32'h0000_0200, 10'd3, 1, 1'b1, 0, 3, 3, 13, 1};
        vt[3] = '{2'b01, 32'h0000_0300, 32'h0000_0300, 10'd0, 0, 1'b1, 0, 0, 0, 1, 1};
        vt[4] = '{2'b11, 32'h0000_0100, 32'h0000_0000, 10'd5, 0, 1'b0, 0, 0, 0, 0, 0};
        vt[5] = '{2'b10, 32'h0000_0040, 32'h0000_0700, 10'd0, 0, 1'b1, 0, 0, 0, 1, 1};

        for (int i = 0; i < 16384; i++) sram[i] = 32'hC000_0000 | 32'(i);
        for (int i = 0; i < 4; i++) dram[dkey(32'h100 + 32'(4 * i))] = 32'(i + 1);
        sram[4] = 32'd7; sram[5] = 32'd8; sram[6] = 32'd9;

        reset = 1'b1; dmaCmd = 2'b00; dmaSrcAddress = '0; dmaDstAddress = '0; dmaWidth = '0;
        sramRd = '0; dramRd = '0; dramAck = 1'b0;
        repeat (2) cyc();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sramWe", 32'(sramWe), 32'd0);
        check("rst_dramReq", 32'(dramReq), 32'd0);
        check("rst_dramWe", 32'(dramWe), 32'd0);
        check("rst_dramAddr", dramAddr, 32'd0);
        check("rst_sramAddr", 32'(sramAddr), 32'd0);
        reset = 1'b0;
        cyc();

        for (int i = 0; i < NV; i++) begin
            run_xfer(vt[i].cmd, vt[i].src, vt[i].dst, vt[i].w, vt[i].delay, vt[i].run, swr, hs, dwr, bsy, dn);
            check($sformatf("v%0d_sram_writes", i), 32'(swr), 32'(vt[i].swr));
            check($sformatf("v%0d_dram_handshakes", i), 32'(hs), 32'(vt[i].hs));
            check($sformatf("v%0d_dram_writes", i), 32'(dwr), 32'(vt[i].dwr));
            check($sformatf("v%0d_busy_cycles", i), 32'(bsy), 32'(vt[i].bsy));
            check($sformatf("v%0d_done_pulses", i), 32'(dn), 32'(vt[i].dn));
        end
        for (int i = 0; i < 4; i++) check($sformatf("d2s_sram_%0d", i), sram[i], 32'(i + 1));
        for (int i = 0; i < 3; i++) check($sformatf("s2d_dram_%0d", i), dram_rd(32'h200 + 32'(4 * i)), 32'(7 + i));

        // Stray ack while idle must not start anything.
        b_swr = n_swr; b_hs = n_hs; b_dwr = n_dwr; b_bsy = n_busy;
        stray_ack = 1'b1;
        repeat (4) cyc();
        check("stray_ack_busy", 32'(n_busy - b_bsy), 32'd0);
        check("stray_ack_activity", 32'((n_swr - b_swr) + (n_hs - b_hs) + (n_dwr - b_dwr)), 32'd0);

        // A second command mid-transfer is dropped.
        for (int i = 0; i < 8; i++) dram[dkey(32'h400 + 32'(4 * i))] = 32'h1000 + 32'(i);
        b_swr = n_swr; b_dwr = n_dwr; b_dn = n_done; b_bsy = n_busy;
        ack_delay = 1;
        dmaCmd = 2'b01; dmaSrcAddress = 32'h400; dmaDstAddress = 32'h40; dmaWidth = 10'd8;
        cyc();
        dmaCmd = 2'b00;
        repeat (5) cyc();
        dmaCmd = 2'b10; dmaSrcAddress = 32'h40; dmaDstAddress = 32'h600; dmaWidth = 10'd3;
        cyc();
        dmaCmd = 2'b00;
        k = 0;
        while (n_done == b_dn && k < 500) begin cyc(); k++; end
        repeat (4) cyc();
        check("midcmd_done", 32'(n_done - b_dn), 32'd1);
        check("midcmd_sram_writes", 32'(n_swr - b_swr), 32'd8);
        check("midcmd_dram_writes", 32'(n_dwr - b_dwr), 32'd0);
        check("midcmd_busy_cycles", 32'(n_busy - b_bsy), 32'd25);
        check("midcmd_no_dram_dst", 32'(dram.exists(dkey(32'h600))), 32'd0);
        for (int i = 0; i < 8; i++) check($sformatf("midcmd_sram_%0d", i), sram[16 + i], 32'h1000 + 32'(i));

        // Reset during word 2 of 4 aborts at once; earlier words stay written.
        for (int i = 0; i < 4; i++) begin
            dram[dkey(32'h800 + 32'(4 * i))] = 32'h2000 + 32'(i);
            sram[32 + i] = 32'hAAAA_0000 + 32'(i);
        end
        b_swr = n_swr;
        ack_delay = 2;
        dmaCmd = 2'b01; dmaSrcAddress = 32'h800; dmaDstAddress = 32'h80; dmaWidth = 10'd4;
        cyc();
        dmaCmd = 2'b00;
        k = 0;
        while (!((n_swr - b_swr) == 2 && dramReq) && k < 200) begin cyc(); k++; end
        check("abort_reached_word2", 32'(dramReq), 32'd1);
        reset = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_dramReq", 32'(dramReq), 32'd0);
        check("abort_dramAddr", dramAddr, 32'd0);
        check("abort_sramWe", 32'(sramWe), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        cyc();
        reset = 1'b0;
        cyc();
        check("abort_sram_0", sram[32], 32'h2000);
        check("abort_sram_1", sram[33], 32'h2001);
        check("abort_sram_2", sram[34], 32'hAAAA_0002);
        check("abort_sram_3", sram[35], 32'hAAAA_0003);
        run_xfer(2'b01, 32'h800, 32'h80, 10'd4, 0, 1'b1, swr, hs, dwr, bsy, dn);
        check("post_abort_writes", 32'(swr), 32'd4);
        check("post_abort_done", 32'(dn), 32'd1);
        for (int i = 0; i < 4; i++) check($sformatf("post_abort_sram_%0d", i), sram[32 + i], 32'h2000 + 32'(i));

        // Random transfers against an array-copy reference.
        for (int t = 0; t < 30; t++) begin
            cmd = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
            w   = 10'($urandom_range(0, 12));
            d   = int'($urandom_range(0, 3));
            src = $urandom & 32'hFFFF_FFFC;
            dst = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 3) == 0) src = 32'hFFFF_FFF0;
            if ($urandom_range(0, 3) == 0) dst = (dst & 32'hFFFF_0000) | 32'h0000_FFF0;
            expv.delete();
            for (int i = 0; i < int'(w); i++) begin
                if (cmd == 2'b01) begin
                    expv.push_back(dram_rd(src + 32'(4 * i)));
                end else begin
                    sidx = 14'((src >> 2) + 32'(i));
                    sram[sidx] = $urandom;
                    expv.push_back(sram[sidx]);
                end
            end
            run_xfer(cmd, src, dst, w, d, 1'b1, swr, hs, dwr, bsy, dn);
            exp_bsy = (w == 10'd0) ? 1 : int'(w) * (d + ((cmd == 2'b01) ? 2 : 3)) + 1;
            check($sformatf("rnd%0d_done", t), 32'(dn), 32'd1);
            check($sformatf("rnd%0d_busy", t), 32'(bsy), 32'(exp_bsy));
            check($sformatf("rnd%0d_handshakes", t), 32'(hs), 32'(w));
            check($sformatf("rnd%0d_sram_writes", t), 32'(swr), (cmd == 2'b01) ? 32'(w) : 32'd0);
            check($sformatf("rnd%0d_dram_writes", t), 32'(dwr), (cmd == 2'b10) ? 32'(w) : 32'd0);
            for (int i = 0; i < int'(w); i++) begin
                if (cmd == 2'b01)
                    check($sformatf("rnd%0d_sram_w%0d", t, i), sram[14'((dst >> 2) + 32'(i))], expv[i]);
                else
                    check($sformatf("rnd%0d_dram_w%0d", t, i), dram_rd(dst + 32'(4 * i)), expv[i]);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached, actual running required finished");
        $fatal(1);
    end

endmodule
